// File: rtl/ex_muldiv_seq.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with a final sign fix-up cycle before HI/LO are written.
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [2*XLEN-1:0] acc_reg;     // multiply: {product_hi, multiplier}; divide: {rem, quo}
  logic [XLEN-1:0]   opnd_reg;    // |multiplicand| or |divisor|
  logic [XLEN-1:0]   a_orig_reg;
  logic              is_div_reg, neg_res_reg, neg_rem_reg, dz_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg;
  logic              done_reg;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign accept = start && (state_reg == IDLE) && !flush;
  assign a_neg  = op[0] && A[XLEN-1];
  assign b_neg  = op[0] && B[XLEN-1];
  assign a_abs  = a_neg ? -A : A;
  assign b_abs  = b_neg ? -B : B;

  // Shift-add step: conditional add into the upper half, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[XLEN-1:1]}
                               : {1'b0, acc_reg[2*XLEN-1:1]};

  // Restoring step: keep the shifted remainder when the trial subtraction borrows.
  assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

  assign mul_res = neg_res_reg ? -acc_reg : acc_reg;

  always_comb begin
    fix_hi = mul_res[2*XLEN-1:XLEN];
    fix_lo = mul_res[XLEN-1:0];
    if (is_div_reg) begin
      if (dz_reg) begin
        fix_hi = a_orig_reg;
        fix_lo = '1;
      end else begin
        fix_lo = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        fix_hi = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (flush)                              state_next = IDLE;
        else if (count_reg == CW'(XLEN - 1))    state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      a_orig_reg  <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      dz_reg      <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg   <= '0;
            is_div_reg  <= op[1];
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            dz_reg      <= (B == '0);
            a_orig_reg  <= A;
            opnd_reg    <= op[1] ? b_abs : a_abs;
            acc_reg     <= {{XLEN{1'b0}}, (op[1] ? a_abs : b_abs)};
          end
        end
        RUN: begin
          if (!flush) begin
            acc_reg   <= is_div_reg ? div_next : mul_next;
            count_reg <= count_reg + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi_reg   <= fix_hi;
            lo_reg   <= fix_lo;
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_reg != IDLE);
  assign stall = accept || (state_reg != IDLE);
  assign done  = done_reg;
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: drivers push expected HI/LO and done cycle into a
// scoreboard queue; a monitor pops and compares on every done pulse.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done (cycle %0d)", hi, lo, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_hi", {32'd0, hi}, {32'd0, e.hi});
        chk("done_lo", {32'd0, lo}, {32'd0, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 45 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got %0d outstanding, expected 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    sb.push_back('{eh, el, cyc + 34});
    @(negedge clk);
    // Operand changes after acceptance must not matter.
    start = 1'b0; op = ~o; A = ~a; B = ~b;
    wait_drain();
  endtask

  initial begin
    int k, n;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy_stall_done", {61'd0, busy, stall, done}, 64'd0);
    rst_n = 1'b1;

    // MULTU max*max with stall window check.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    k = cyc;
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, k + 34});
    n = 0;
    #1;
    for (int i = 0; i < 34; i++) begin
      if (stall) n++;
      @(negedge clk);
      start = 1'b0; A = 32'h1; B = 32'h2;
      #1;
    end
    chk("stall_cycles", 64'(n), 64'd34);
    chk("stall_in_done_cycle", {63'd0, stall}, 64'd0);
    wait_drain();

    issue(2'b01, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b10, 32'd100,       32'd7,          32'd2,         32'd14);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000);
    issue(2'b11, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF);
    issue(2'b10, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF);

    // Flush mid-multiply: no write, no done; then a fresh start.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd6;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_keeps_hi", {32'd0, hi}, 64'h0000_1234);
    chk("flush_keeps_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    issue(2'b00, 32'd5, 32'd6, 32'd0, 32'd30);

    // Back-to-back: second start in the done cycle of the first.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd4;
    sb.push_back('{32'd0, 32'd12, cyc + 34});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 45 && !done; i++) @(negedge clk);
    start = 1'b1; op = 2'b10; A = 32'd50; B = 32'd5;
    sb.push_back('{32'd0, 32'd10, cyc + 34});
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Flush and start together in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9;
    #1;
    chk("flush_start_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 2'b11; A = 32'hFFFF_FF9C; B = 32'd3;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_hi", {32'd0, hi}, 64'd0);
    chk("midop_reset_lo", {32'd0, lo}, 64'd0);
    chk("midop_reset_busy_stall_done", {61'd0, busy, stall, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (40) @(negedge clk);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
